// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per request, answers after WAIT_CYCLES wait states.
// Optional misalignment trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        dmReq,
    input  logic        dmSignal,
    input  logic [1:0]  dmSize,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmStData,
    output logic [31:0] dmLdData,
    output logic        dmReady,
    output logic        dmErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sig_q, sig_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] st_q, st_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             out_of_range;
    logic             misalign;
    logic             bad;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_data;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             wr_en;

    assign word_idx     = addr_q[IDX_W+1:2];
    assign out_of_range = |addr_q[31:IDX_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad = out_of_range || misalign;

    // Low address bits below the access size are dropped, forcing natural alignment.
    always_comb begin
        lane = 2'b00;
        case (size_q)
            2'b00:   lane = addr_q[1:0];
            2'b01:   lane = {addr_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    // NOTE: every signal gets a default at the top of a combinational block, so no latch is inferred.
    always_comb begin
        ld_data = 32'h0;
        wr_be   = 4'b0000;
        wr_data = st_q;
        case (size_q)
            2'b00: begin
                ld_data = {24'h0, rd_shift[7:0]};
                wr_be   = 4'b0001 << lane;
                wr_data = {4{st_q[7:0]}};
            end
            2'b01: begin
                ld_data = {16'h0, rd_shift[15:0]};
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{st_q[15:0]}};
            end
            default: begin
                ld_data = rd_word;
                wr_be   = 4'b1111;
            end
        endcase
    end

    // A reset during RESP returns state_q to IDLE before the edge, so no write can commit.
    assign wr_en = (state_q == RESP) && sig_q && !bad;

    // NOTE: the memory array has no reset; its contents survive arstn and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state values come from _d.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sig_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            st_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sig_d    = sig_q;
        size_d   = size_q;
        addr_d   = addr_q;
        st_d     = st_q;
        dmReady  = 1'b0;
        dmErr    = 1'b0;
        dmLdData = 32'h0;
        case (state_q)
            IDLE: begin
                if (dmReq) begin
                    sig_d   = dmSignal;
                    size_d  = dmSize;
                    addr_d  = dmAddr;
                    st_d    = dmStData;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                dmReady  = 1'b1;
                dmErr    = bad;
                dmLdData = (!sig_q && !bad) ? ld_data : 32'h0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=1024): directed vector table
// plus hand-written sequences for back-to-back requests and reset in WAIT/RESP.
module tb_dmem_responder;

    logic        clk;
    logic        arstn;
    logic        dmReq;
    logic        dmSignal;
    logic [1:0]  dmSize;
    logic [31:0] dmAddr;
    logic [31:0] dmStData;
    logic [31:0] dmLdData;
    logic        dmReady;
    logic        dmErr;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk      (clk),
        .arstn    (arstn),
        .dmReq    (dmReq),
        .dmSignal (dmSignal),
        .dmSize   (dmSize),
        .dmAddr   (dmAddr),
        .dmStData (dmStData),
        .dmLdData (dmLdData),
        .dmReady  (dmReady),
        .dmErr    (dmErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_ld;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic st, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_ld, input logic exp_err);
        vec_t v;
        v.name = name; v.st = st; v.size = size; v.addr = addr;
        v.wdata = wdata; v.exp_ld = exp_ld; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Starts from any point with the DUT idle or in its final RESP cycle; returns at the
    // negedge where dmReady is seen (or after the timeout, with lat beyond the budget).
    task automatic do_access(input logic st, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, output int lat,
                             output logic [31:0] ld, output logic err);
        int l;
        @(negedge clk);
        dmReq = 1'b1; dmSignal = st; dmSize = sz; dmAddr = a; dmStData = wd;
        @(posedge clk);
        for (l = 1; l <= 16; l++) begin
            @(negedge clk);
            dmReq = 1'b0;
            if (dmReady) break;
            @(posedge clk);
        end
        lat = l;
        ld  = dmLdData;
        err = dmErr;
    endtask

    initial begin
        int          lat;
        logic [31:0] ld;
        logic        err;
        int          last;
        int          n_ready;

        arstn = 1'b0; dmReq = 1'b0; dmSignal = 1'b0; dmSize = 2'b00;
        dmAddr = 32'h0; dmStData = 32'h0;

        add("sw_10",        1'b1, 2'b10, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
        add("lw_10",        1'b0, 2'b10, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
        add("sb_13",        1'b1, 2'b00, 32'h13,   32'h0000005A, 32'h0,        1'b0);
        add("lw_10_b",      1'b0, 2'b10, 32'h10,   32'h0,        32'h5AADBEEF, 1'b0);
        add("lb_12",        1'b0, 2'b00, 32'h12,   32'h0,        32'h000000AD, 1'b0);
        add("lh_12",        1'b0, 2'b01, 32'h12,   32'h0,        32'h00005AAD, 1'b0);
        add("lb_10",        1'b0, 2'b00, 32'h10,   32'h0,        32'h000000EF, 1'b0);
        add("lb_11",        1'b0, 2'b00, 32'h11,   32'h0,        32'h000000BE, 1'b0);
        add("lh_10",        1'b0, 2'b01, 32'h10,   32'h0,        32'h0000BEEF, 1'b0);
        add("l_size11",     1'b0, 2'b11, 32'h10,   32'h0,        32'h5AADBEEF, 1'b0);
        add("sw_0",         1'b1, 2'b10, 32'h0,    32'h11223344, 32'h0,        1'b0);
        add("lw_0",         1'b0, 2'b10, 32'h0,    32'h0,        32'h11223344, 1'b0);
        add("sw_oor",       1'b1, 2'b10, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b1);
        add("lw_0_after",   1'b0, 2'b10, 32'h0,    32'h0,        32'h11223344, 1'b0);
        add("lb_oor",       1'b0, 2'b00, 32'h1000, 32'h0,        32'h0,        1'b1);
        add("lw_oor_hi",    1'b0, 2'b10, 32'h80000010, 32'h0,    32'h0,        1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
        add("lw_12_mis",    1'b0, 2'b10, 32'h12,   32'h0,        32'h0,        1'b1);
        add("lh_11_mis",    1'b0, 2'b01, 32'h11,   32'h0,        32'h0,        1'b1);
`else
        add("lw_12_mis",    1'b0, 2'b10, 32'h12,   32'h0,        32'h5AADBEEF, 1'b0);
        add("lh_11_mis",    1'b0, 2'b01, 32'h11,   32'h0,        32'h0000BEEF, 1'b0);
`endif
        add("sw_14",        1'b1, 2'b10, 32'h14,   32'h00000000, 32'h0,        1'b0);
        add("sh_16",        1'b1, 2'b01, 32'h16,   32'hFFFF9876, 32'h0,        1'b0);
        add("sb_14",        1'b1, 2'b00, 32'h14,   32'hFFFFFF77, 32'h0,        1'b0);
        add("lw_14",        1'b0, 2'b10, 32'h14,   32'h0,        32'h98760077, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'h0, dmReady}, 32'h0);
        check("reset_err",   {31'h0, dmErr},   32'h0);
        check("reset_ld",    dmLdData,         32'h0);
        arstn = 1'b1;

        foreach (vecs[i]) begin
            do_access(vecs[i].st, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, ld, err);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
            check({vecs[i].name, "_err"}, {31'h0, err}, {31'h0, vecs[i].exp_err});
            if (!vecs[i].st || vecs[i].exp_err)
                check({vecs[i].name, "_ld"}, ld, vecs[i].exp_ld);
        end

        // dmReq held high: responses every 3 cycles, each returning the half at 0x12
        @(negedge clk);
        dmReq = 1'b1; dmSignal = 1'b0; dmSize = 2'b01; dmAddr = 32'h12;
        last = 0; n_ready = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dmReady) begin
                check("b2b_ld", dmLdData, 32'h00005AAD);
                if (last == 0) check("b2b_first", 32'(c), 32'd2);
                else           check("b2b_spacing", 32'(c - last), 32'd3);
                last = c;
                n_ready++;
            end
        end
        dmReq = 1'b0;
        check("b2b_count", 32'(n_ready), 32'd4);

        // Reset pulsed in WAIT: store abandoned
        @(negedge clk);
        dmReq = 1'b1; dmSignal = 1'b1; dmSize = 2'b10; dmAddr = 32'h0; dmStData = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        dmReq = 1'b0;
        arstn = 1'b0;
        #1;
        check("rst_wait_ready", {31'h0, dmReady}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        n_ready = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dmReady) n_ready++;
        end
        check("rst_wait_no_ready", 32'(n_ready), 32'd0);
        do_access(1'b0, 2'b10, 32'h0, 32'h0, lat, ld, err);
        check("rst_wait_readback", ld, 32'h11223344);

        // Reset asserted during RESP: outputs drop at once, store not committed
        do_access(1'b1, 2'b10, 32'h0, 32'h0BADF00D, lat, ld, err);
        check("rst_resp_lat", 32'(lat), 32'd2);
        arstn = 1'b0;
        #1;
        check("rst_resp_ready", {31'h0, dmReady}, 32'h0);
        check("rst_resp_err",   {31'h0, dmErr},   32'h0);
        check("rst_resp_ld",    dmLdData,         32'h0);
        @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        do_access(1'b0, 2'b10, 32'h0, 32'h0, lat, ld, err);
        check("rst_resp_readback", ld, 32'h11223344);
        check("rst_resp_rb_err", {31'h0, err}, 32'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
